// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, transfer-size encodings and size legality check
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;
  function automatic logic size_legal(input logic [3:0] xfer_size);
    return xfer_size == SZ_B || xfer_size == SZ_H || xfer_size == SZ_W || xfer_size == SZ_D;
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane enables within the 8-byte word plus size/alignment/range error
module dmem_lane_align import dmem_pkg::*; #(
  parameter int ADDR_BITS = 10
) (
  input  logic [63:0] i_address,
  input  logic [3:0]  i_xfer_size,
  output logic [7:0]  o_byte_en,
  output logic        o_error
);
  logic [7:0]  w_mask;
  logic        w_misaligned;
  logic        w_out_of_range;
  assign w_mask = i_xfer_size == SZ_D ? 8'hFF :
                  i_xfer_size == SZ_W ? 8'h0F :
                  i_xfer_size == SZ_H ? 8'h03 :
                  i_xfer_size == SZ_B ? 8'h01 : 8'h00;
  assign o_byte_en = w_mask << i_address[2:0];
  assign w_misaligned = |(i_address[2:0] & (i_xfer_size[2:0] - 3'd1));
  // 65-bit sum so addresses near 2**64 cannot wrap back into the array
  assign w_out_of_range = ({1'b0, i_address} + 65'(i_xfer_size)) > (65'd1 << ADDR_BITS);
  assign o_error = !size_legal(i_xfer_size) || w_misaligned || w_out_of_range;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency byte-addressed memory responder for the MEM-stage load/store port
module dmem_responder import dmem_pkg::*; #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] address,
  input  logic [3:0]  xfer_size,
  input  logic [63:0] write_data,
  output logic        resp_valid,
  output logic [63:0] read_data,
  output logic        resp_error,
  output logic        busy
);
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [63:0] r_addr, r_wdata;
  logic [3:0]  r_size;
  logic        r_resp_valid;
  logic [63:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_mem [2**ADDR_BITS];
  logic        w_write, w_commit, w_err;
  logic [63:0] w_addr, w_wdata, w_word, w_rd, w_wsh;
  logic [3:0]  w_size;
  logic [7:0]  w_be;
  // With LATENCY=1 the commit edge is also the accept edge, so use the live request then
  assign w_write = r_state == IDLE ? req_write  : r_write;
  assign w_addr  = r_state == IDLE ? address    : r_addr;
  assign w_size  = r_state == IDLE ? xfer_size  : r_size;
  assign w_wdata = r_state == IDLE ? write_data : r_wdata;
  dmem_lane_align #(.ADDR_BITS(ADDR_BITS)) u_align (
    .i_address   (w_addr),
    .i_xfer_size (w_size),
    .o_byte_en   (w_be),
    .o_error     (w_err)
  );
  always_comb begin
    w_next = r_state == IDLE ? (req_valid ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
             r_state == WAIT ? (r_cnt == 4'd1 ? RESP : WAIT) : IDLE;
    w_commit = w_next == RESP && r_state != RESP && !reset;
  end
  always_comb begin
    w_word = '0;
    for (int l = 0; l < 8; l++)
      w_word[8*l +: 8] = w_be[l] ? r_mem[{w_addr[ADDR_BITS-1:3], 3'(l)}] : 8'h00;
    w_rd  = w_word >> {w_addr[2:0], 3'b000};
    w_wsh = w_wdata << {w_addr[2:0], 3'b000};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_size       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= r_state == RESP;
      if (r_state == IDLE && req_valid) begin
        r_write <= req_write;
        r_addr  <= address;
        r_size  <= xfer_size;
        r_wdata <= write_data;
        r_cnt   <= 4'(LATENCY - 1);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_write) ? '0 : w_rd;
      end
    end
  end
  // Storage is deliberately left out of reset
  always_ff @(posedge clk)
    for (int l = 0; l < 8; l++)
      if (w_commit && !w_err && w_write && w_be[l])
        r_mem[{w_addr[ADDR_BITS-1:3], 3'(l)}] <= w_wsh[8*l +: 8];
  assign req_ready  = r_state == IDLE && !reset;
  assign resp_valid = r_resp_valid;
  assign read_data  = r_rdata;
  assign resp_error = r_err;
  assign busy       = r_state != IDLE;
endmodule
